// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Lookup is combinational; training, flush and statistics are updated on the rising clock edge.
module btb_predictor #(
   parameter int XLEN      = 32,
   parameter int ENTRIES   = 64,
   parameter int TAG_BITS  = 10,
   parameter int CTR_BITS  = 2,
   parameter int PRED_MODE = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc_if,
   output logic            pred_hit,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_next_pc,
   input  logic            upd_valid,
   input  logic [XLEN-1:0] upd_pc,
   input  logic            upd_taken,
   input  logic [XLEN-1:0] upd_target,
   input  logic            upd_pred_taken,
   input  logic [XLEN-1:0] upd_pred_target,
   input  logic            flush,
   output logic            mispredict,
   output logic [31:0]     branch_count,
   output logic [31:0]     mispredict_count
);

   localparam int IDX = $clog2(ENTRIES);
   localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
   localparam logic [CTR_BITS-1:0] CTR_ZERO = {CTR_BITS{1'b0}};
   localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);

   logic                valid_q [ENTRIES];
   logic [TAG_BITS-1:0] tag_q   [ENTRIES];
   logic [XLEN-1:0]     tgt_q   [ENTRIES];
   logic [CTR_BITS-1:0] ctr_q   [ENTRIES];

   logic [31:0] branch_count_q, branch_count_d;
   logic [31:0] mispredict_count_q, mispredict_count_d;

   logic [IDX-1:0]      lk_idx_s, up_idx_s;
   logic [TAG_BITS-1:0] lk_tag_s, up_tag_s;
   logic                up_hit_s;
   logic                unused_pc_bits_s;

   function automatic logic [CTR_BITS-1:0] ctr_inc(input logic [CTR_BITS-1:0] c);
      if (c == CTR_MAX) return c;
      else              return c + CTR_BITS'(1);
   endfunction

   function automatic logic [CTR_BITS-1:0] ctr_dec(input logic [CTR_BITS-1:0] c);
      if (c == CTR_ZERO) return c;
      else               return c - CTR_BITS'(1);
   endfunction

   assign lk_idx_s = pc_if[IDX+1:2];
   assign lk_tag_s = pc_if[IDX+1+TAG_BITS:IDX+2];
   assign up_idx_s = upd_pc[IDX+1:2];
   assign up_tag_s = upd_pc[IDX+1+TAG_BITS:IDX+2];
   assign up_hit_s = valid_q[up_idx_s] && (tag_q[up_idx_s] == up_tag_s);
   // Byte-offset and high PC bits take no part in indexing or tagging.
   assign unused_pc_bits_s = ^{pc_if, upd_pc};

   assign branch_count     = branch_count_q;
   assign mispredict_count = mispredict_count_q;

   // Fetch-side lookup sees the table as it stood before this cycle's edge.
   always_comb begin
      pred_hit     = 1'b0;
      pred_taken   = 1'b0;
      pred_next_pc = pc_if + XLEN'(4);
      pred_hit = valid_q[lk_idx_s] && (tag_q[lk_idx_s] == lk_tag_s);
      if (PRED_MODE == 1) begin
         pred_taken = pred_hit & ctr_q[lk_idx_s][CTR_BITS-1];
      end else begin
         pred_taken = 1'b0;
      end
      if (pred_taken) begin
         pred_next_pc = tgt_q[lk_idx_s];
      end else begin
         pred_next_pc = pc_if + XLEN'(4);
      end
   end

   // Redirect request: wrong direction, or taken with a wrong target.
   always_comb begin
      mispredict = upd_valid & ((upd_taken != upd_pred_taken) |
                   (upd_taken & upd_pred_taken & (upd_target != upd_pred_target)));
   end

   // Saturating statistics next-state.
   always_comb begin
      branch_count_d     = branch_count_q;
      mispredict_count_d = mispredict_count_q;
      if (upd_valid && (branch_count_q != 32'hFFFF_FFFF)) begin
         branch_count_d = branch_count_q + 32'd1;
      end else begin
         branch_count_d = branch_count_q;
      end
      if (mispredict && (mispredict_count_q != 32'hFFFF_FFFF)) begin
         mispredict_count_d = mispredict_count_q + 32'd1;
      end else begin
         mispredict_count_d = mispredict_count_q;
      end
   end

   // Statistics registers; they keep counting even when a flush drops the update.
   always_ff @(posedge clk) begin
      if (rst) begin
         branch_count_q     <= 32'd0;
         mispredict_count_q <= 32'd0;
      end else begin
         branch_count_q     <= branch_count_d;
         mispredict_count_q <= mispredict_count_d;
      end
   end

   // Table training: flush wins over a same-cycle update, reset wins over both.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= CTR_ZERO;
         end
      end else if (flush) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
         end
      end else if (upd_valid) begin
         if (up_hit_s) begin
            if (upd_taken) begin
               ctr_q[up_idx_s] <= ctr_inc(ctr_q[up_idx_s]);
               tgt_q[up_idx_s] <= upd_target;
            end else begin
               ctr_q[up_idx_s] <= ctr_dec(ctr_q[up_idx_s]);
            end
         end else if (upd_taken) begin
            valid_q[up_idx_s] <= 1'b1;
            tag_q[up_idx_s]   <= up_tag_s;
            tgt_q[up_idx_s]   <= upd_target;
            ctr_q[up_idx_s]   <= CTR_WEAK;
         end
      end
   end

endmodule

// File: tb/tb_btb_predictor.sv
// Bench for btb_predictor: directed vector table plus randomized traffic against a table model.
// A PRED_MODE=0 instance shares all inputs with the bimodal instance.
module tb_btb_predictor;

   localparam int XLEN = 32, ENTRIES = 64, TAG_BITS = 10, CTR_BITS = 2;

   logic        clk = 1'b0;
   logic        rst, flush, upd_valid, upd_taken, upd_pred_taken;
   logic [31:0] pc_if, upd_pc, upd_target, upd_pred_target;
   logic        hit1, taken1, misp1, hit0, taken0, misp0;
   logic [31:0] npc1, npc0, bc1, mc1, bc0, mc0;

   int checks = 0;
   int errors = 0;

   bit          m_valid [ENTRIES];
   int unsigned m_tag   [ENTRIES];
   logic [31:0] m_tgt   [ENTRIES];
   int          m_ctr   [ENTRIES];
   longint      m_bc, m_mc;

   typedef struct {
      logic [31:0] pc;
      logic        uv;
      logic [31:0] upc;
      logic        ut;
      logic [31:0] utgt;
      logic        upt;
      logic [31:0] uptgt;
      logic        fl;
      logic        e_hit;
      logic        e_taken;
      logic [31:0] e_npc;
      logic        e_misp;
      logic [31:0] e_bc;
      logic [31:0] e_mc;
   } vec_t;

   vec_t vecs [21];

   always #5 clk = ~clk;

   btb_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES), .TAG_BITS(TAG_BITS), .CTR_BITS(CTR_BITS),
                   .PRED_MODE(1)) dut_bim (
      .clk(clk), .rst(rst), .pc_if(pc_if), .pred_hit(hit1), .pred_taken(taken1),
      .pred_next_pc(npc1), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
      .upd_pred_target(upd_pred_target), .flush(flush), .mispredict(misp1),
      .branch_count(bc1), .mispredict_count(mc1));

   btb_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES), .TAG_BITS(TAG_BITS), .CTR_BITS(CTR_BITS),
                   .PRED_MODE(0)) dut_static (
      .clk(clk), .rst(rst), .pc_if(pc_if), .pred_hit(hit0), .pred_taken(taken0),
      .pred_next_pc(npc0), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
      .upd_pred_target(upd_pred_target), .flush(flush), .mispredict(misp0),
      .branch_count(bc0), .mispredict_count(mc0));

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc / 32'd4) % 32'(ENTRIES));
   endfunction

   function automatic int unsigned tag_of(input logic [31:0] pc);
      return (pc / 32'(4 * ENTRIES)) % 32'(1 << TAG_BITS);
   endfunction

   function automatic bit exp_misp();
      if (!upd_valid) return 1'b0;
      if (upd_taken != upd_pred_taken) return 1'b1;
      return upd_taken && (upd_target != upd_pred_target);
   endfunction

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      int i;
      if (rst) begin
         for (int k = 0; k < ENTRIES; k++) begin
            m_valid[k] = 1'b0;
            m_ctr[k]   = 0;
         end
         m_bc = 0;
         m_mc = 0;
         return;
      end
      if (upd_valid && m_bc < 64'hFFFF_FFFF) m_bc++;
      if (exp_misp() && m_mc < 64'hFFFF_FFFF) m_mc++;
      if (flush) begin
         for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
      end else if (upd_valid) begin
         i = idx_of(upd_pc);
         if (m_valid[i] && m_tag[i] == tag_of(upd_pc)) begin
            if (upd_taken) begin
               m_ctr[i] = (m_ctr[i] + 1 > (1 << CTR_BITS) - 1) ? m_ctr[i] : m_ctr[i] + 1;
               m_tgt[i] = upd_target;
            end else begin
               m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
            end
         end else if (upd_taken) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = tag_of(upd_pc);
            m_tgt[i]   = upd_target;
            m_ctr[i]   = 1 << (CTR_BITS - 1);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic check_model();
      int          i;
      bit          h, t;
      logic [31:0] npc;
      i   = idx_of(pc_if);
      h   = m_valid[i] && (m_tag[i] == tag_of(pc_if));
      t   = h && (m_ctr[i] >= (1 << (CTR_BITS - 1)));
      npc = t ? m_tgt[i] : pc_if + 32'd4;
      cmp("rnd_hit", 32'(hit1), 32'(h));
      cmp("rnd_taken", 32'(taken1), 32'(t));
      cmp("rnd_next_pc", npc1, npc);
      cmp("rnd_mispredict", 32'(misp1), 32'(exp_misp()));
      cmp("rnd_branch_count", bc1, 32'(m_bc));
      cmp("rnd_mispredict_count", mc1, 32'(m_mc));
      cmp("rnd_static_hit", 32'(hit0), 32'(h));
      cmp("rnd_static_taken", 32'(taken0), 32'd0);
      cmp("rnd_static_next_pc", npc0, pc_if + 32'd4);
      cmp("rnd_static_branch_count", bc0, 32'(m_bc));
   endtask

   function automatic logic [31:0] rand_pc();
      logic [31:0] p;
      p = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2) |
          32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) p = p | ($urandom & 32'hFFFC_0000);
      return p;
   endfunction

   initial begin
      //          pc            uv    upc        ut    utgt      upt   uptgt     fl    hit   tkn   npc           misp  bc     mc
      vecs[0]  = '{32'h100,      1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 32'h104,      1'b0, 32'd0, 32'd0};
      vecs[1]  = '{32'h100,      1'b1, 32'h100,  1'b1, 32'h40,   1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 32'h104,      1'b1, 32'd0, 32'd0};
      vecs[2]  = '{32'h100,      1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b1, 1'b1, 32'h40,       1'b0, 32'd1, 32'd1};
      vecs[3]  = '{32'h100,      1'b1, 32'h100,  1'b0, 32'h0,    1'b1, 32'h40,   1'b0, 1'b1, 1'b1, 32'h40,       1'b1, 32'd1, 32'd1};
      vecs[4]  = '{32'h100,      1'b1, 32'h100,  1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 32'h104,      1'b0, 32'd2, 32'd2};
      vecs[5]  = '{32'h100,      1'b1, 32'h100,  1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 32'h104,      1'b0, 32'd3, 32'd2};
      vecs[6]  = '{32'h100,      1'b1, 32'h100,  1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 32'h104,      1'b0, 32'd4, 32'd2};
      vecs[7]  = '{32'h100,      1'b1, 32'h100,  1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 32'h104,      1'b0, 32'd5, 32'd2};
      vecs[8]  = '{32'h100,      1'b1, 32'h100,  1'b1, 32'h40,   1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 32'h104,      1'b1, 32'd6, 32'd2};
      vecs[9]  = '{32'h100,      1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 32'h104,      1'b0, 32'd7, 32'd3};
      vecs[10] = '{32'h100,      1'b1, 32'h200,  1'b1, 32'h80,   1'b1, 32'h80,   1'b0, 1'b1, 1'b0, 32'h104,      1'b0, 32'd7, 32'd3};
      vecs[11] = '{32'h100,      1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 32'h104,      1'b0, 32'd8, 32'd3};
      vecs[12] = '{32'h200,      1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b1, 1'b1, 32'h80,       1'b0, 32'd8, 32'd3};
      vecs[13] = '{32'h200,      1'b1, 32'h200,  1'b1, 32'h90,   1'b1, 32'h80,   1'b0, 1'b1, 1'b1, 32'h80,       1'b1, 32'd8, 32'd3};
      vecs[14] = '{32'h200,      1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b1, 1'b1, 32'h90,       1'b0, 32'd9, 32'd4};
      vecs[15] = '{32'h200,      1'b1, 32'h300,  1'b1, 32'h44,   1'b0, 32'h0,    1'b1, 1'b1, 1'b1, 32'h90,       1'b1, 32'd9, 32'd4};
      vecs[16] = '{32'h200,      1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 32'h204,      1'b0, 32'd10, 32'd5};
      vecs[17] = '{32'h300,      1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 32'h304,      1'b0, 32'd10, 32'd5};
      vecs[18] = '{32'h400,      1'b1, 32'h400,  1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 32'h404,      1'b0, 32'd10, 32'd5};
      vecs[19] = '{32'h400,      1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 32'h404,      1'b0, 32'd11, 32'd5};
      vecs[20] = '{32'hFFFFFFFC, 1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'd11, 32'd5};

      // Reset held while a taken update is presented: reset must win.
      rst = 1'b1; flush = 1'b0; pc_if = 32'h100;
      upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h40;
      upd_pred_taken = 1'b0; upd_pred_target = 32'h0;
      tick();
      tick();
      @(negedge clk);
      cmp("reset_branch_count", bc1, 32'd0);
      cmp("reset_mispredict_count", mc1, 32'd0);
      cmp("reset_hit", 32'(hit1), 32'd0);
      cmp("reset_mispredict_comb", 32'(misp1), 32'd1);
      tick();
      rst = 1'b0;

      for (int v = 0; v < 21; v++) begin
         pc_if           = vecs[v].pc;
         upd_valid       = vecs[v].uv;
         upd_pc          = vecs[v].upc;
         upd_taken       = vecs[v].ut;
         upd_target      = vecs[v].utgt;
         upd_pred_taken  = vecs[v].upt;
         upd_pred_target = vecs[v].uptgt;
         flush           = vecs[v].fl;
         @(negedge clk);
         cmp($sformatf("vec%0d_hit", v), 32'(hit1), 32'(vecs[v].e_hit));
         cmp($sformatf("vec%0d_taken", v), 32'(taken1), 32'(vecs[v].e_taken));
         cmp($sformatf("vec%0d_next_pc", v), npc1, vecs[v].e_npc);
         cmp($sformatf("vec%0d_mispredict", v), 32'(misp1), 32'(vecs[v].e_misp));
         cmp($sformatf("vec%0d_branch_count", v), bc1, vecs[v].e_bc);
         cmp($sformatf("vec%0d_mispredict_count", v), mc1, vecs[v].e_mc);
         cmp($sformatf("vec%0d_static_hit", v), 32'(hit0), 32'(vecs[v].e_hit));
         cmp($sformatf("vec%0d_static_taken", v), 32'(taken0), 32'd0);
         cmp($sformatf("vec%0d_static_next_pc", v), npc0, vecs[v].pc + 32'd4);
         cmp($sformatf("vec%0d_static_mispredict", v), 32'(misp0), 32'(vecs[v].e_misp));
         tick();
      end

      for (int n = 0; n < 600; n++) begin
         rst             = ($urandom_range(0, 199) == 0);
         flush           = ($urandom_range(0, 39) == 0);
         upd_valid       = ($urandom_range(0, 3) != 0);
         upd_pc          = rand_pc();
         upd_taken       = 1'($urandom_range(0, 1));
         upd_target      = $urandom;
         upd_pred_taken  = 1'($urandom_range(0, 1));
         upd_pred_target = ($urandom_range(0, 1) == 0) ? upd_target : $urandom;
         pc_if           = ($urandom_range(0, 1) == 0) ? upd_pc : rand_pc();
         @(negedge clk);
         check_model();
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
